seg7_scan_dev: RTL and testbench
================================

SEG7_SCAN_DEV -- requirements
Module: seg7_scan_dev

Interface
REQ-001 Parameter DIGITS, default 4, SHALL set the number of multiplexed digits; legal range 1..8.
REQ-002 Parameter SCAN_DIV, default 50000, SHALL set the clocks per digit slot; legal range 2..2^20.
REQ-003 Parameter BLINK_FRAMES, default 64, SHALL set the full scan frames per blink half-period; legal range 1..1023.
REQ-004 clk  input  1  single clock; all state SHALL be updated on its rising edge.
REQ-005 rst  input  1  SHALL be an asynchronous, active-high reset.
REQ-006 wr_en  input  1  SHALL mean a register write on this clock edge.
REQ-007 addr  input  2  register select: 0=HEX, 1=CTRL, 2=RAW_LO, 3=RAW_HI.
REQ-008 wr_data  input  32  write data.
REQ-009 rd_data  output  32  read data of the register selected by addr, combinational.
REQ-010 SEGMENT  output  8  active-low segments {dp,g,f,e,d,c,b,a}, registered.
REQ-011 AN_SEL  output  DIGITS  active-low digit enables, registered, one-hot-low or all ones.

Function
REQ-012 HEX register (32b) SHALL hold digit i's nibble in bits [4i+3:4i].
REQ-013 CTRL register SHALL hold: bit0 mode (0=hex, 1=raw), bits[15:8] dp mask, bits[23:16] blink mask; other bits SHALL read 0, and mask bits >= DIGITS SHALL read 0.
REQ-014 RAW_LO and RAW_HI SHALL hold the active-low raw segment byte for digits 0-3 and 4-7, at bits [8(i%4)+7:8(i%4)]; with DIGITS<=4, RAW_HI SHALL be writable but never displayed.
REQ-015 A write SHALL update the addressed register at the edge where wr_en=1; rd_data SHALL reflect it from the next cycle.
REQ-016 Prescaler SHALL count 0..SCAN_DIV-1 and wrap; at the terminal count, digit index SHALL advance by 1, wrapping DIGITS-1 -> 0.
REQ-017 A frame SHALL end when the index wraps to 0; frame counter SHALL count frames 0..BLINK_FRAMES-1, and blink phase SHALL toggle at its wrap.
REQ-018 Output registers SHALL load every clock from the current index and register contents, giving exactly 1 cycle latency from any index or register change to SEGMENT/AN_SEL.
REQ-019 AN_SEL SHALL drive bit idx low and all other bits high, except all bits high when blink phase=1 and blink mask bit idx=1.
REQ-020 Hex mode: SEGMENT[6:0] SHALL be the standard active-low encoding of nibble idx (0->7'h40, 1->7'h79, 8->7'h00, F->7'h0E), and SEGMENT[7] SHALL equal NOT dp mask bit idx.
REQ-021 Raw mode: SEGMENT SHALL equal the raw byte of digit idx, and the dp mask SHALL be ignored.
REQ-022 A write coinciding with a prescaler wrap SHALL perform both; the new digit SHALL show the new value one cycle later.
REQ-023 A write to CTRL changing mode or masks SHALL NOT reset the prescaler, index, frame counter or blink phase.
REQ-024 With DIGITS=1, the index SHALL stay 0, and every prescaler wrap SHALL count as a frame.

Reset
REQ-025 While rst=1: prescaler, index, frame counter, blink phase, HEX, CTRL, RAW_LO and RAW_HI SHALL be 0, SEGMENT=8'hFF, and AN_SEL=all ones.
REQ-026 Reset asserted mid-operation SHALL blank outputs immediately (asynchronously), without waiting for a clock edge.
REQ-027 On the first edge after rst deasserts, outputs SHALL show digit 0: AN_SEL=~1, and SEGMENT=8'hC0 for HEX=0.

Verification (DIGITS=4, SCAN_DIV=4, BLINK_FRAMES=2)
REQ-028 Write HEX=32'h0000F810, mode 0 -> AN_SEL cycles E,D,B,7 every 4 clocks, with SEGMENT C0,F9,80,8E respectively.
REQ-029 CTRL=32'h0000_0201 with RAW_LO=32'h12345678 -> digit0 shows 8'h78, digit2 shows 8'h34; dp mask ignored.
REQ-030 Mode 0, CTRL dp mask=8'h02 -> SEGMENT[7]=0 only while AN_SEL=4'hD.
REQ-031 Blink mask=8'h01 -> digit 0 is lit in frames 0-1, AN_SEL=4'hF during its slot in frames 2-3, and the pattern repeats every 4 frames.
REQ-032 Write HEX on the prescaler terminal-count edge -> the next digit shows the new nibble exactly 1 cycle after the edge.
REQ-033 Assert rst between clock edges mid-frame -> SEGMENT=FF and AN_SEL=F with no clock edge, all registers read 0, and the scan restarts at digit 0.

Source files
------------

// File: rtl/seg7_scan_dev.sv
// rtl/seg7_scan_dev.sv - multiplexed 7-segment scanner with hex/raw modes, dp and blink masks
module seg7_scan_dev #(
    parameter int DIGITS       = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [1:0]        addr,
    input  logic [31:0]       wr_data,
    output logic [31:0]       rd_data,
    output logic [7:0]        SEGMENT,
    output logic [DIGITS-1:0] AN_SEL
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int FW = 10;

    localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
    localparam logic [FW-1:0] FRM_LAST = FW'(BLINK_FRAMES - 1);
    // Mask bits for digits that do not exist are never stored, so they read 0.
    localparam logic [7:0]    DIG_MASK = 8'((1 << DIGITS) - 1);

    // Scan timing state
    logic [PW-1:0] pre_q, pre_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [FW-1:0] frm_q, frm_d;
    logic          blink_q, blink_d;

    // Register file
    logic [31:0] hex_q, hex_d;
    logic        mode_q, mode_d;
    logic [7:0]  dp_q, dp_d;
    logic [7:0]  bm_q, bm_d;
    logic [31:0] raw_lo_q, raw_lo_d;
    logic [31:0] raw_hi_q, raw_hi_d;

    // Output registers
    logic [7:0]        seg_q, seg_d;
    logic [DIGITS-1:0] an_q, an_d;

    // Digit-dependent selection helpers
    logic [2:0]  idx_w;
    logic [3:0]  nib;
    logic [63:0] raw_all;
    logic [7:0]  raw_b;

    // Active-low {g,f,e,d,c,b,a} pattern for one hex nibble.
    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0:    hex7 = 7'h40;
            4'h1:    hex7 = 7'h79;
            4'h2:    hex7 = 7'h24;
            4'h3:    hex7 = 7'h30;
            4'h4:    hex7 = 7'h19;
            4'h5:    hex7 = 7'h12;
            4'h6:    hex7 = 7'h02;
            4'h7:    hex7 = 7'h78;
            4'h8:    hex7 = 7'h00;
            4'h9:    hex7 = 7'h10;
            4'hA:    hex7 = 7'h08;
            4'hB:    hex7 = 7'h03;
            4'hC:    hex7 = 7'h46;
            4'hD:    hex7 = 7'h21;
            4'hE:    hex7 = 7'h06;
            default: hex7 = 7'h0E;
        endcase
    endfunction

    // Prescaler -> digit index -> frame counter -> blink phase cascade.
    always_comb begin
        pre_d   = pre_q;
        idx_d   = idx_q;
        frm_d   = frm_q;
        blink_d = blink_q;
        if (pre_q == PRE_LAST) begin
            pre_d = '0;
            if (idx_q == IDX_LAST) begin
                // Index wrapping to 0 ends a frame (every wrap when DIGITS=1).
                idx_d = '0;
                if (frm_q == FRM_LAST) begin
                    frm_d   = '0;
                    blink_d = ~blink_q;
                end else begin
                    frm_d = frm_q + 1'b1;
                end
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end else begin
            pre_d = pre_q + 1'b1;
        end
    end

    // Register writes; CTRL writes only touch mode/masks, never scan state.
    always_comb begin
        hex_d    = hex_q;
        mode_d   = mode_q;
        dp_d     = dp_q;
        bm_d     = bm_q;
        raw_lo_d = raw_lo_q;
        raw_hi_d = raw_hi_q;
        if (wr_en) begin
            case (addr)
                2'd0: hex_d = wr_data;
                2'd1: begin
                    mode_d = wr_data[0];
                    dp_d   = wr_data[15:8] & DIG_MASK;
                    bm_d   = wr_data[23:16] & DIG_MASK;
                end
                2'd2: raw_lo_d = wr_data;
                default: raw_hi_d = wr_data;
            endcase
        end
    end

    // Combinational register readback.
    always_comb begin
        case (addr)
            2'd0:    rd_data = hex_q;
            2'd1:    rd_data = {8'h00, bm_q, dp_q, 7'h00, mode_q};
            2'd2:    rd_data = raw_lo_q;
            default: rd_data = raw_hi_q;
        endcase
    end

    // Next segment/anode pattern from the current index and registers.
    always_comb begin
        idx_w   = 3'(idx_q);
        nib     = hex_q[{idx_w, 2'b00} +: 4];
        raw_all = {raw_hi_q, raw_lo_q};
        raw_b   = raw_all[{idx_w, 3'b000} +: 8];
        if (mode_q) begin
            seg_d = raw_b;
        end else begin
            seg_d = {~dp_q[idx_w], hex7(nib)};
        end
        an_d = '1;
        if (!(blink_q && bm_q[idx_w])) begin
            an_d[idx_q] = 1'b0;
        end
    end

    // State and output registers; reset blanks the display immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q    <= '0;
            idx_q    <= '0;
            frm_q    <= '0;
            blink_q  <= 1'b0;
            hex_q    <= '0;
            mode_q   <= 1'b0;
            dp_q     <= '0;
            bm_q     <= '0;
            raw_lo_q <= '0;
            raw_hi_q <= '0;
            seg_q    <= 8'hFF;
            an_q     <= '1;
        end else begin
            pre_q    <= pre_d;
            idx_q    <= idx_d;
            frm_q    <= frm_d;
            blink_q  <= blink_d;
            hex_q    <= hex_d;
            mode_q   <= mode_d;
            dp_q     <= dp_d;
            bm_q     <= bm_d;
            raw_lo_q <= raw_lo_d;
            raw_hi_q <= raw_hi_d;
            seg_q    <= seg_d;
            an_q     <= an_d;
        end
    end

    assign SEGMENT = seg_q;
    assign AN_SEL  = an_q;

endmodule

// File: tb/tb_seg7_scan_dev.sv
// tb/tb_seg7_scan_dev.sv - directed table-driven bench for seg7_scan_dev
module tb_seg7_scan_dev;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [1:0]  addr = 2'd0;
    logic [31:0] wr_data = 32'h0;
    logic [31:0] rd_data;
    logic [7:0]  SEGMENT;
    logic [3:0]  AN_SEL;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;

    seg7_scan_dev #(.DIGITS(4), .SCAN_DIV(4), .BLINK_FRAMES(2)) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .addr    (addr),
        .wr_data (wr_data),
        .rd_data (rd_data),
        .SEGMENT (SEGMENT),
        .AN_SEL  (AN_SEL)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hex;
        logic [31:0] ctrl;
        logic [31:0] raw;
        int          dig;
        logic [7:0]  seg;
        logic [3:0]  an;
        logic [31:0] ctrl_rd;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance one clock; samples are taken 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    task automatic run_to(input int n);
        while (edge_n < n) tick();
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        wr_en   = 1'b1;
        addr    = a;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        wr_en = 1'b0;
        tick();
        tick();
        rst    = 1'b0;
        edge_n = 0;
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string name);
        addr = a;
        #1;
        chk(name, rd_data, exp);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [7:0] seg_scan [4];
        logic [3:0] an_scan [4];
        seg_scan = '{8'hC0, 8'hF9, 8'h80, 8'h8E};
        an_scan  = '{4'hE, 4'hD, 4'hB, 4'h7};

        //          hex           ctrl          raw           dig seg    an    ctrl_rd
        vecs[0]  = '{32'h0000F810, 32'h00000000, 32'h00000000, 0, 8'hC0, 4'hE, 32'h00000000};
        vecs[1]  = '{32'h0000F810, 32'h00000000, 32'h00000000, 1, 8'hF9, 4'hD, 32'h00000000};
        vecs[2]  = '{32'h0000F810, 32'h00000000, 32'h00000000, 2, 8'h80, 4'hB, 32'h00000000};
        vecs[3]  = '{32'h0000F810, 32'h00000000, 32'h00000000, 3, 8'h8E, 4'h7, 32'h00000000};
        vecs[4]  = '{32'h00000000, 32'h00000201, 32'h12345678, 0, 8'h78, 4'hE, 32'h00000201};
        vecs[5]  = '{32'h00000000, 32'h00000201, 32'h12345678, 1, 8'h56, 4'hD, 32'h00000201};
        vecs[6]  = '{32'h00000000, 32'h00000201, 32'h12345678, 2, 8'h34, 4'hB, 32'h00000201};
        vecs[7]  = '{32'h0000F810, 32'h00000200, 32'h00000000, 1, 8'h79, 4'hD, 32'h00000200};
        vecs[8]  = '{32'h0000F810, 32'h00000200, 32'h00000000, 0, 8'hC0, 4'hE, 32'h00000200};
        vecs[9]  = '{32'h0000F810, 32'h00000200, 32'h00000000, 2, 8'h80, 4'hB, 32'h00000200};
        vecs[10] = '{32'h0000A5C3, 32'h00000000, 32'h00000000, 0, 8'hB0, 4'hE, 32'h00000000};
        vecs[11] = '{32'h0000A5C3, 32'h00000000, 32'h00000000, 1, 8'hC6, 4'hD, 32'h00000000};
        vecs[12] = '{32'h00007642, 32'h00000000, 32'h00000000, 2, 8'h82, 4'hB, 32'h00000000};
        vecs[13] = '{32'h00007642, 32'h00000000, 32'h00000000, 3, 8'hF8, 4'h7, 32'h00000000};
        vecs[14] = '{32'h0000EDB9, 32'h00000000, 32'h00000000, 1, 8'h83, 4'hD, 32'h00000000};
        vecs[15] = '{32'h00000000, 32'h0000FF01, 32'h12345678, 3, 8'h12, 4'h7, 32'h00000F01};

        // Reset state
        #1;
        tick();
        tick();
        chk("rst_seg", {24'h0, SEGMENT}, 32'hFF);
        chk("rst_an", {28'h0, AN_SEL}, 32'hF);
        rd(2'd0, 32'h0, "rst_hex");
        rd(2'd1, 32'h0, "rst_ctrl");
        rd(2'd2, 32'h0, "rst_rawlo");
        rd(2'd3, 32'h0, "rst_rawhi");

        // First edge after release, then full scan with HEX=F810
        rst = 1'b0;
        edge_n = 0;
        wr(2'd0, 32'h0000F810);
        chk("first_seg", {24'h0, SEGMENT}, 32'hC0);
        chk("first_an", {28'h0, AN_SEL}, 32'hE);
        for (int k = 2; k <= 16; k++) begin
            tick();
            chk($sformatf("scan_an_e%0d", k), {28'h0, AN_SEL}, {28'h0, an_scan[((k - 1) / 4) % 4]});
            chk($sformatf("scan_seg_e%0d", k), {24'h0, SEGMENT}, {24'h0, seg_scan[((k - 1) / 4) % 4]});
        end

        // Table: registers written on edges 1-3, digit d checked on edge 4d+4
        for (int i = 0; i < 16; i++) begin
            do_reset();
            wr(2'd0, vecs[i].hex);
            wr(2'd1, vecs[i].ctrl);
            wr(2'd2, vecs[i].raw);
            run_to(4 * vecs[i].dig + 4);
            chk($sformatf("vec%0d_seg", i), {24'h0, SEGMENT}, {24'h0, vecs[i].seg});
            chk($sformatf("vec%0d_an", i), {28'h0, AN_SEL}, {28'h0, vecs[i].an});
            rd(2'd1, vecs[i].ctrl_rd, $sformatf("vec%0d_ctrl_rd", i));
        end

        // Register readback and masking of nonexistent digits
        do_reset();
        wr(2'd1, 32'hFFFFFFFF);
        rd(2'd1, 32'h000F0F01, "ctrl_mask_rd");
        wr(2'd3, 32'hAABBCCDD);
        rd(2'd3, 32'hAABBCCDD, "rawhi_rd");
        wr(2'd0, 32'h89ABCDEF);
        rd(2'd0, 32'h89ABCDEF, "hex_rd");

        // Write on the prescaler terminal-count edge (edge 4: digit 0 -> 1)
        do_reset();
        run_to(3);
        rd(2'd0, 32'h0, "tc_hex_before");
        wr(2'd0, 32'h00000050);
        chk("tc_seg_e4", {24'h0, SEGMENT}, 32'hC0);
        chk("tc_an_e4", {28'h0, AN_SEL}, 32'hE);
        rd(2'd0, 32'h50, "tc_hex_after");
        tick();
        chk("tc_seg_e5", {24'h0, SEGMENT}, 32'h92);
        chk("tc_an_e5", {28'h0, AN_SEL}, 32'hD);

        // Blink on digit 0; a CTRL write mid-run must not disturb scan/blink state
        do_reset();
        wr(2'd1, 32'h00010000);
        chk("blink_f0", {28'h0, AN_SEL}, 32'hE);
        run_to(18);
        chk("blink_f1", {28'h0, AN_SEL}, 32'hE);
        run_to(19);
        wr(2'd1, 32'h00010001);
        run_to(34);
        chk("blink_f2", {28'h0, AN_SEL}, 32'hF);
        run_to(38);
        chk("blink_f2_d1", {28'h0, AN_SEL}, 32'hD);
        run_to(50);
        chk("blink_f3", {28'h0, AN_SEL}, 32'hF);
        run_to(55);
        chk("blink_f3_d1", {28'h0, AN_SEL}, 32'hD);
        chk("blink_raw_seg", {24'h0, SEGMENT}, 32'h00);
        run_to(66);
        chk("blink_f4", {28'h0, AN_SEL}, 32'hE);
        run_to(98);
        chk("blink_f6", {28'h0, AN_SEL}, 32'hF);

        // Asynchronous reset between edges mid-frame
        do_reset();
        wr(2'd0, 32'h0000F810);
        wr(2'd1, 32'h00000200);
        wr(2'd2, 32'h00000011);
        wr(2'd3, 32'h00000022);
        run_to(10);
        chk("mid_seg", {24'h0, SEGMENT}, 32'h80);
        chk("mid_an", {28'h0, AN_SEL}, 32'hB);
        #1;
        rst = 1'b1;
        #2;
        chk("async_seg", {24'h0, SEGMENT}, 32'hFF);
        chk("async_an", {28'h0, AN_SEL}, 32'hF);
        rd(2'd0, 32'h0, "async_hex");
        rd(2'd1, 32'h0, "async_ctrl");
        rd(2'd2, 32'h0, "async_rawlo");
        rd(2'd3, 32'h0, "async_rawhi");
        tick();
        rst = 1'b0;
        edge_n = 0;
        tick();
        chk("restart_seg", {24'h0, SEGMENT}, 32'hC0);
        chk("restart_an", {28'h0, AN_SEL}, 32'hE);
        run_to(5);
        chk("restart_an_e5", {28'h0, AN_SEL}, 32'hD);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
